// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared constants and state encoding for the PS/2 key event decoder.
package ps2_pkg;

    // Prefix bytes that modify the code that follows them
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Bit positions of the flags inside a 10-bit key event
    localparam int EV_EXT = 9;
    localparam int EV_BRK = 8;

    // Width of one key event {ext, brk, code}
    localparam int EV_WIDTH = 10;

    // Prefix decoder states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Bus bundle between the byte receiver / CPU peripheral side and the decoder.
interface ps2_key_event_decoder_if #(
    parameter int FIFO_DEPTH = 16
);
    import ps2_pkg::*;

    logic                          iReady;
    logic [7:0]                    iScanCode;
    logic                          iRead;
    logic                          iClearOvf;
    logic [EV_WIDTH-1:0]           oEvent;
    logic                          oEmpty;
    logic [$clog2(FIFO_DEPTH):0]   oCount;
    logic                          oOverflow;

    // Receiver/CPU side drives bytes and reads events
    modport master (
        output iReady, iScanCode, iRead, iClearOvf,
        input  oEvent, oEmpty, oCount, oOverflow
    );

    // Decoder side
    modport slave (
        input  iReady, iScanCode, iRead, iClearOvf,
        output oEvent, oEmpty, oCount, oOverflow
    );

endinterface

// File: rtl/ps2_key_event_decoder_sync_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on rd_data while not empty.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO may accept a write alongside a read
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Storage array, cleared so the head reads as zero after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Turns PS/2 scan-code bytes into {extended, break, code} key events queued in a FIFO.
module ps2_key_event_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int PREFIX_TIMEOUT = 2500000
) (
    input  logic                   iCLK,
    input  logic                   iRST_n,
    ps2_key_event_decoder_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(PREFIX_TIMEOUT - 1);

    logic                sync1;
    logic                sync2;
    logic                sync3;
    logic                strobe;
    dec_state_t          state;
    dec_state_t          next_state;
    logic [TW-1:0]       tcnt;
    logic                wr_en;
    logic [EV_WIDTH-1:0] ev_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic                drop;
    logic                overflow;

    // Two-flop synchroniser for the receiver's ready level plus an edge register
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= bus.iReady;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // One strobe per ready pulse; the scan code bus has long been stable by then
    assign strobe = sync2 & ~sync3;

    // Prefix state register
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Prefix decode: prefixes only move the state, any other byte emits an event
    always_comb begin
        next_state       = state;
        wr_en            = 1'b0;
        ev_data          = '0;
        ev_data[7:0]     = bus.iScanCode;
        ev_data[EV_EXT]  = (state == ST_EXT) || (state == ST_EXT_BRK);
        ev_data[EV_BRK]  = (state == ST_BRK) || (state == ST_EXT_BRK);
        if (strobe) begin
            if (bus.iScanCode == PS2_EXT) begin
                next_state = ST_EXT;
            end else if (bus.iScanCode == PS2_BRK) begin
                case (state)
                    ST_IDLE: next_state = ST_BRK;
                    ST_EXT:  next_state = ST_EXT_BRK;
                    default: next_state = state;
                endcase
            end else begin
                wr_en      = 1'b1;
                next_state = ST_IDLE;
            end
        end else if ((state != ST_IDLE) && (tcnt == TMAX)) begin
            next_state = ST_IDLE;
        end
    end

    // Silence timer: a stale prefix is dropped if no byte follows in time
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            tcnt <= '0;
        end else if (strobe || (state == ST_IDLE)) begin
            tcnt <= '0;
        end else if (tcnt != TMAX) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (EV_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (iCLK),
        .rst_n   (iRST_n),
        .wr_en   (wr_en),
        .wr_data (ev_data),
        .rd_en   (bus.iRead),
        .rd_data (bus.oEvent),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // An event is lost only when full and no pop makes room in the same cycle
    assign drop = wr_en & fifo_full & ~(bus.iRead & ~fifo_empty);

    // Sticky overflow flag; a new drop beats a simultaneous clear
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (bus.iClearOvf) begin
            overflow <= 1'b0;
        end
    end

    assign bus.oEmpty    = fifo_empty;
    assign bus.oCount    = fifo_count;
    assign bus.oOverflow = overflow;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed, table-driven bench for the PS/2 key event decoder.
module tb_ps2_key_event_decoder;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 32;

    logic iCLK;
    logic iRST_n;
    int   checks;
    int   errors;

    ps2_key_event_decoder_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_key_event_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .PREFIX_TIMEOUT (TIMEOUT)
    ) dut (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] bytes;
        logic [2:0]  n;
        logic [9:0]  ev;
    } vec_t;

    vec_t vecs [10];

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Hard stop in case something stalls the stimulus
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One ready pulse carrying a byte; rd/clr are pulsed on exactly the decode edge
    task automatic sendByte(input logic [7:0] b, input logic rd, input logic clr);
        @(negedge iCLK);
        bus.iScanCode = b;
        bus.iReady    = 1'b1;
        @(posedge iCLK);
        @(posedge iCLK);
        @(negedge iCLK);
        bus.iRead     = rd;
        bus.iClearOvf = clr;
        @(negedge iCLK);
        bus.iRead     = 1'b0;
        bus.iClearOvf = 1'b0;
        repeat (3) @(negedge iCLK);
        bus.iReady = 1'b0;
        repeat (4) @(negedge iCLK);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        sendByte(b, 1'b0, 1'b0);
    endtask

    task automatic popEvent();
        @(negedge iCLK);
        bus.iRead = 1'b1;
        @(negedge iCLK);
        bus.iRead = 1'b0;
    endtask

    task automatic pulseClear();
        @(negedge iCLK);
        bus.iClearOvf = 1'b1;
        @(negedge iCLK);
        bus.iClearOvf = 1'b0;
    endtask

    initial begin
        logic [7:0]  bt;
        logic [31:0] word;

        checks = 0;
        errors = 0;
        bus.iReady    = 1'b0;
        bus.iScanCode = 8'h00;
        bus.iRead     = 1'b0;
        bus.iClearOvf = 1'b0;

        vecs[0] = '{32'h1C000000, 3'd1, 10'h01C};
        vecs[1] = '{32'hF01C0000, 3'd2, 10'h11C};
        vecs[2] = '{32'hE0750000, 3'd2, 10'h275};
        vecs[3] = '{32'hE0F07500, 3'd3, 10'h375};
        vecs[4] = '{32'hE0E07400, 3'd3, 10'h274};
        vecs[5] = '{32'hE1000000, 3'd1, 10'h0E1};
        vecs[6] = '{32'hAA000000, 3'd1, 10'h0AA};
        vecs[7] = '{32'hF0F01C00, 3'd3, 10'h11C};
        vecs[8] = '{32'hF0E01100, 3'd3, 10'h211};
        vecs[9] = '{32'hE0F0F07C, 3'd4, 10'h37C};

        iRST_n = 1'b0;
        repeat (3) @(negedge iCLK);
        checkOutput("reset_empty", 32'(bus.oEmpty), 32'd1);
        checkOutput("reset_count", 32'(bus.oCount), 32'd0);
        checkOutput("reset_ovf",   32'(bus.oOverflow), 32'd0);
        checkOutput("reset_event", 32'(bus.oEvent), 32'd0);
        iRST_n = 1'b1;
        repeat (2) @(negedge iCLK);

        // Latency: the event appears after the third rising edge following iReady
        bus.iScanCode = 8'h1C;
        bus.iReady    = 1'b1;
        @(posedge iCLK);
        @(posedge iCLK);
        @(negedge iCLK);
        checkOutput("lat_empty_edge2", 32'(bus.oEmpty), 32'd1);
        @(posedge iCLK);
        @(negedge iCLK);
        checkOutput("lat_empty_edge3", 32'(bus.oEmpty), 32'd0);
        checkOutput("lat_event", 32'(bus.oEvent), 32'h01C);
        checkOutput("lat_count", 32'(bus.oCount), 32'd1);
        repeat (6) @(negedge iCLK);
        checkOutput("lat_single_strobe", 32'(bus.oCount), 32'd1);
        bus.iReady = 1'b0;
        repeat (4) @(negedge iCLK);
        popEvent();
        checkOutput("lat_pop_empty", 32'(bus.oEmpty), 32'd1);

        // Prefix combinations from the vector table
        for (int i = 0; i < 10; i++) begin
            word = vecs[i].bytes;
            for (int j = 0; j < int'(vecs[i].n); j++) begin
                bt = word[31-8*j -: 8];
                applyStimulus(bt);
                if (j < int'(vecs[i].n) - 1) begin
                    checkOutput($sformatf("vec%0d_prefix_count", i), 32'(bus.oCount), 32'd0);
                end
            end
            checkOutput($sformatf("vec%0d_event", i), 32'(bus.oEvent), 32'(vecs[i].ev));
            checkOutput($sformatf("vec%0d_count", i), 32'(bus.oCount), 32'd1);
            popEvent();
            checkOutput($sformatf("vec%0d_empty", i), 32'(bus.oEmpty), 32'd1);
        end

        // Stale extended prefix is discarded after the silence timeout
        applyStimulus(8'hE0);
        repeat (TIMEOUT + 8) @(negedge iCLK);
        applyStimulus(8'h75);
        checkOutput("timeout_event", 32'(bus.oEvent), 32'h075);
        popEvent();

        // Overflow: one more code than the FIFO holds
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(8'h10 + 8'(i));
        end
        checkOutput("ovf_count", 32'(bus.oCount), 32'(DEPTH));
        checkOutput("ovf_flag",  32'(bus.oOverflow), 32'd1);
        checkOutput("ovf_head",  32'(bus.oEvent), 32'h010);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("ovf_order%0d", i), 32'(bus.oEvent), 32'h010 + 32'(i));
            popEvent();
        end
        checkOutput("ovf_drained", 32'(bus.oEmpty), 32'd1);
        pulseClear();
        checkOutput("ovf_cleared", 32'(bus.oOverflow), 32'd0);

        // Full FIFO with a write and a read on the same edge
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(8'h20 + 8'(i));
        end
        sendByte(8'h55, 1'b1, 1'b0);
        checkOutput("fullrw_count", 32'(bus.oCount), 32'(DEPTH));
        checkOutput("fullrw_ovf",   32'(bus.oOverflow), 32'd0);
        checkOutput("fullrw_head",  32'(bus.oEvent), 32'h021);
        for (int i = 0; i < DEPTH - 1; i++) begin
            popEvent();
        end
        checkOutput("fullrw_tail", 32'(bus.oEvent), 32'h055);
        popEvent();
        checkOutput("fullrw_empty", 32'(bus.oEmpty), 32'd1);

        // Reading an empty FIFO leaves pointers alone
        popEvent();
        checkOutput("rd_empty_count", 32'(bus.oCount), 32'd0);
        applyStimulus(8'h33);
        checkOutput("rd_empty_next", 32'(bus.oEvent), 32'h033);
        checkOutput("rd_empty_cnt1", 32'(bus.oCount), 32'd1);
        popEvent();

        // A drop on the same edge as a clear leaves the flag set
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(8'h40 + 8'(i));
        end
        sendByte(8'h66, 1'b0, 1'b1);
        checkOutput("setwins_ovf",   32'(bus.oOverflow), 32'd1);
        checkOutput("setwins_count", 32'(bus.oCount), 32'(DEPTH));

        // Reset between a break prefix and its code discards everything
        applyStimulus(8'hF0);
        @(negedge iCLK);
        iRST_n = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST_n = 1'b1;
        @(negedge iCLK);
        checkOutput("midrst_count0", 32'(bus.oCount), 32'd0);
        applyStimulus(8'h1C);
        checkOutput("midrst_event", 32'(bus.oEvent), 32'h01C);
        checkOutput("midrst_ovf",   32'(bus.oOverflow), 32'd0);
        checkOutput("midrst_count", 32'(bus.oCount), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard byte receiver (PS/2-clock domain, `ready` level plus 8-bit scan code).
- Brings each received byte into the system clock domain and decodes the 0xE0 (extended) and 0xF0 (break) prefixes.
- Pushes one 10-bit key event per make/break code into a first-word-fall-through FIFO.
- The FIFO is read by the memory-mapped keyboard peripheral on the CPU bus.

Parameters:
- FIFO_DEPTH, 16, number of event entries; power of two, ≥2.
- PREFIX_TIMEOUT, 2500000, iCLK cycles without a new byte after which a pending prefix is discarded (50 ms at 50 MHz).

Ports:
- iCLK  in  1  system clock.
- iRST_n  in  1  asynchronous active-low reset.
- iReady  in  1  byte-valid level from receiver, PS/2-clock domain; high ≥1 PS/2 clock period.
- iScanCode  in  8  received byte; stable whenever iReady is high.
- iRead  in  1  pop head event (single-cycle pulse, iCLK domain).
- iClearOvf  in  1  clear the sticky overflow flag.
- oEvent  out  10  head event: [9]=extended, [8]=break, [7:0]=code; valid when oEmpty=0.
- oEmpty  out  1  FIFO empty.
- oCount  out  $clog2(FIFO_DEPTH)+1  entries held.
- oOverflow  out  1  sticky: at least one event was dropped.

Behaviour:
- Reset (async, iRST_n=0):
  - sync flops, edge register, prefix state, timeout counter and FIFO pointers cleared.
  - oEmpty=1, oCount=0, oOverflow=0, oEvent=0.
- Input synchronisation:
  - iReady passes through a 2-flop synchroniser, then a third edge register.
  - Strobe = sync2 & ~sync3.
  - On the 3rd iCLK rising edge after iReady rises, iScanCode is captured and decoded (bus already stable; no multi-bit sync needed).
  - Exactly one strobe per iReady high pulse, regardless of pulse length.
- Decode FSM states:
  - IDLE: no prefix pending.
  - EXT: 0xE0 seen.
  - BRK: 0xF0 seen.
  - EXT_BRK: 0xE0 then 0xF0 seen.
- FSM transitions on strobe:
  - 0xE0: any state → EXT (a repeated E0 restarts the sequence). No write.
  - 0xF0: IDLE → BRK; EXT → EXT_BRK; BRK and EXT_BRK stay. No write.
  - Any other byte: write event {ext, brk, byte}, where ext=1 in EXT/EXT_BRK and brk=1 in BRK/EXT_BRK; then → IDLE.
  - 0xE1, 0xAA, 0xFA and 0xFE are not special; they are emitted as ordinary codes.
- Prefix timeout:
  - Counter reloads to 0 on every strobe and increments while state ≠ IDLE.
  - When it reaches PREFIX_TIMEOUT-1 → IDLE; nothing is emitted.
  - Counter saturates; it is held at 0 in IDLE.
- FIFO (FWFT):
  - oEvent = mem[rd_ptr] combinationally.
  - Write occurs on the same edge as the decode.
  - oEmpty deasserts and oCount increments on the edge that writes.
- FIFO boundary conditions:
  - iRead while empty: ignored, no pointer change.
  - Write while full with no iRead that cycle: event dropped, oOverflow←1, count unchanged.
  - Write while full with iRead same cycle: both proceed, count stays FIFO_DEPTH, no overflow.
  - Write + read while non-full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow flag:
  - iClearOvf clears oOverflow.
  - If a drop coincides with iClearOvf, set wins.
- Reset asserted mid-sequence or mid-synchronisation: all state discarded; no partial event survives.

Decomposition:
- Package ps2_pkg:
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0.
  - event bit indices EV_EXT=9, EV_BRK=8.
  - FSM state encoding.
- Sub-module sync_fifo (parameterised WIDTH, DEPTH; FWFT; full, empty and count outputs).
- Synchroniser, FSM and timeout counter live in the top module.

Test Plan:
- Reset, then a single iReady pulse (3 PS/2-clock periods long) with 0x1C → after the 3rd edge oEmpty=0, oEvent=10'h01C, oCount=1. iRead → oEmpty=1.
- Bytes F0,1C → one event 10'h11C. Bytes E0,75 → 10'h275. Bytes E0,F0,75 → 10'h375. Prefix bytes never raise oCount.
- E0 followed by silence for PREFIX_TIMEOUT cycles, then 0x75 → event 10'h075 (prefix discarded). Also E0,E0,74 → 10'h274.
- FIFO_DEPTH+1 make codes, no reads:
  - oCount=FIFO_DEPTH, oOverflow=1, head is the first code.
  - Read all → codes in order, last dropped.
  - iClearOvf → oOverflow=0.
- FIFO full, new strobe coinciding with iRead → count stays FIFO_DEPTH, oOverflow stays 0, new code appears at tail. iRead while empty → no change.
- iRST_n pulsed low between F0 and 1C → the following 1C yields 10'h01C with oOverflow=0 and oCount=1.
